rgmii_link_ctrl: RTL and testbench
==================================

# rgmii_link_ctrl

MDIO management controller that tracks PHY link state and schedules access to the single MDIO bus. It periodically reads the PHY status register and publishes `speed`, `link_up` and `duplex`; `speed` drives the RGMII PHY interface's 2-bit speed select. A host register-access port shares the same MDIO bus through a two-requester arbiter (poller vs host).

## Interface
- PHY_ADDR, 5'd0, MDIO PHY address used for all frames
- MDC_DIV, 20, clk cycles per MDC half-period (≥2)
- POLL_INTERVAL, 1000000, clk cycles from end of one poll (or reset) to next poll request
- POLL_REG, 5'h11, PHY status register address; fields: [15:14] speed, [13] duplex, [10] link
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  host request valid
- req_ready  out  1  host request accepted when req_valid && req_ready
- req_write  in  1  1 = write, 0 = read
- req_reg  in  5  register address
- req_wdata  in  16  write data
- rsp_valid  out  1  one-cycle pulse: host transaction done
- rsp_rdata  out  16  read data, valid with rsp_valid (0 for writes)
- mdc  out  1  MDIO clock
- mdio_i  in  1  MDIO input
- mdio_o  out  1  MDIO output data
- mdio_oe  out  1  MDIO output enable
- speed  out  2  00 10M, 01 100M, 10 1000M
- link_up  out  1  PHY link status
- duplex  out  1  1 = full duplex
- status_valid  out  1  sticky, set after first completed poll
- link_change  out  1  one-cycle pulse when link_up toggles

## Operation
- Reset values: mdc 0, mdio_o 1, mdio_oe 0, req_ready 0, rsp_valid 0, rsp_rdata 0, speed 2'b10, link_up 0, duplex 1, status_valid 0, link_change 0; poll timer 0, no poll pending.
- States: IDLE, FRAME, DONE. req_ready = 1 only in IDLE with no grant to poller that cycle.
- Poll timer counts in IDLE/FRAME/DONE; at POLL_INTERVAL-1 sets poll_pending, stops until poll completes, then restarts from 0.
- Arbitration in IDLE: if poll_pending and (no host req or last grant was host) → poll; else host req → host. Host can never be granted twice in a row while poll_pending.
- Frame (64 bits, MSB first): bits 0-31 preamble 1s; 32-33 ST 01; 34-35 OP (read 10, write 01); 36-40 PHYAD; 41-45 REGAD; 46-47 TA; 48-63 data.
- Write: mdio_oe 1 for all 64 bits, TA = 10. Read: mdio_oe 1 bits 0-45, 0 bits 46-63; data sampled from mdio_i on MDC rising edge of bits 48-63.
- DONE (1 cycle): mdio_oe 0, mdio_o 1. Host: rsp_valid pulse with rsp_rdata. Poll: update status, set status_valid; rsp_valid not asserted.
- Poll update: link_up = bit10, duplex = bit13; speed = [15:14] only if link bit 1 and field ≠ 11, else speed holds. link_change when new link_up ≠ old.
- Reset mid-frame: immediate return to reset values, no response issued.

## Timing
- MDC: div counter 0..MDC_DIV-1; toggles mdc at terminal count; period 2*MDC_DIV cycles. mdc idles low outside FRAME.
- mdio_o/mdio_oe change only on MDC falling edge (bit 0 driven in the cycle after grant while mdc low); sampling on rising edge.
- Latency: handshake at cycle T → rsp_valid at T + 128*MDC_DIV + 1.
- Host req_* must be held stable only until handshake; values latched at accept.

## Structure
- Package mdio_pkg: frame length 64, preamble length 32, bit-position constants, ST/opcode constants, speed encodings (10M/100M/1000M), status field bit indices.
- Sub-module mdio_master: single-frame engine (MDC divider, 64-bit shift, tristate control, read capture) with start/done handshake; rgmii_link_ctrl holds poll timer, arbiter and status registers.

## Test plan
- MDC_DIV=2, POLL_INTERVAL=200; after reset PHY model returns 0x6400 on reg 0x11 → speed 01... correction: 0x6400 = speed 01, duplex 1, link 1; expect link_up 1, speed 01, link_change pulse, status_valid 1.
- Host read reg 0x02, model returns 0x001C → rsp_rdata 0x001C exactly 257 cycles after handshake; mdio_oe 0 from bit 46.
- Host write reg 0x00 data 0x1140 → captured frame 32x1,01,01,00000,00000,10,0x1140; rsp_valid with rsp_rdata 0.
- Continuous host requests while poll_pending → grants alternate host/poll; poll never starved.
- Poll returns 0x8000 (link down) after link up at 100M → link_up 0, speed stays 01, link_change pulse; returns 0xE400 (speed 11) → speed unchanged.
- rst asserted at bit 40 of host read → mdc 0, mdio_oe 0, no rsp_valid; next request completes normally.

Source files
------------

// File: rtl/mdio_pkg.sv
// Shared MDIO frame layout, PHY status field positions and the
// request bundle passed from the link controller to the frame engine.
package mdio_pkg;

  localparam int FRAME_LEN = 64;
  localparam int PRE_LEN   = 32;
  localparam int BIT_ST    = PRE_LEN;
  localparam int BIT_OP    = 34;
  localparam int BIT_PHYAD = 36;
  localparam int BIT_REGAD = 41;
  localparam int BIT_TA    = 46;
  localparam int BIT_DATA  = 48;

  localparam logic [1:0] ST_CODE = 2'b01;
  localparam logic [1:0] OP_RD   = 2'b10;
  localparam logic [1:0] OP_WR   = 2'b01;
  localparam logic [1:0] TA_WR   = 2'b10;

  localparam logic [1:0] SPD_10M   = 2'b00;
  localparam logic [1:0] SPD_100M  = 2'b01;
  localparam logic [1:0] SPD_1000M = 2'b10;

  localparam int STS_SPD    = 14;
  localparam int STS_DUPLEX = 13;
  localparam int STS_LINK   = 10;

  typedef struct packed {
    logic        write;
    logic [4:0]  regad;
    logic [15:0] wdata;
  } mdio_req_t;

  // Read frames leave TA/data as ones; the driver is off there anyway.
  function automatic logic [FRAME_LEN-1:0] build_frame(
    input mdio_req_t  r,
    input logic [4:0] phyad
  );
    logic [FRAME_LEN-1:0] f;
    f = '1;
    f[FRAME_LEN-1-BIT_ST -: 2]    = ST_CODE;
    f[FRAME_LEN-1-BIT_OP -: 2]    = r.write ? OP_WR : OP_RD;
    f[FRAME_LEN-1-BIT_PHYAD -: 5] = phyad;
    f[FRAME_LEN-1-BIT_REGAD -: 5] = r.regad;
    if (r.write) begin
      f[FRAME_LEN-1-BIT_TA -: 2]    = TA_WR;
      f[FRAME_LEN-1-BIT_DATA -: 16] = r.wdata;
    end
    return f;
  endfunction

  function automatic logic spd_ok(input logic [1:0] s);
    return (s == SPD_10M) || (s == SPD_100M) || (s == SPD_1000M);
  endfunction

endpackage

// File: rtl/mdio_master.sv
// Single MDIO frame engine: MDC divider, 64-bit shifter, driver
// enable control and read-data capture, started by a one-cycle start.
module mdio_master
  import mdio_pkg::*;
#(
  parameter logic [4:0] PHY_ADDR = 5'd0,
  parameter int         MDC_DIV  = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  mdio_req_t   req,
  input  logic        mdio_i,
  output logic        mdc,
  output logic        mdio_o,
  output logic        mdio_oe,
  output logic        done,
  output logic [15:0] rdata
);

  localparam int DW = $clog2(MDC_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(MDC_DIV - 1);

  logic [FRAME_LEN-1:0] frame;
  logic [FRAME_LEN-2:0] sh;
  logic [DW-1:0]        div;
  logic [5:0]           bit_cnt;
  logic [5:0]           nxt;
  logic                 busy;
  logic                 wr;

  assign frame = build_frame(req, PHY_ADDR);
  assign nxt   = bit_cnt + 6'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy    <= 1'b0;
      wr      <= 1'b0;
      sh      <= '1;
      div     <= '0;
      bit_cnt <= '0;
      mdc     <= 1'b0;
      mdio_o  <= 1'b1;
      mdio_oe <= 1'b0;
      done    <= 1'b0;
      rdata   <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        busy    <= 1'b1;
        wr      <= req.write;
        sh      <= frame[FRAME_LEN-2:0];
        mdio_o  <= frame[FRAME_LEN-1];
        mdio_oe <= 1'b1;
        div     <= '0;
        bit_cnt <= '0;
        mdc     <= 1'b0;
        rdata   <= '0;
      end else if (busy) begin
        if (div != DIV_LAST) begin
          div <= div + 1'b1;
        end else begin
          div <= '0;
          mdc <= ~mdc;
          if (!mdc) begin
            if (!wr && bit_cnt >= 6'(BIT_DATA))
              rdata <= {rdata[14:0], mdio_i};
          end else if (bit_cnt == 6'(FRAME_LEN - 1)) begin
            busy    <= 1'b0;
            done    <= 1'b1;
            mdio_oe <= 1'b0;
            mdio_o  <= 1'b1;
          end else begin
            // Next bit launches on the MDC falling edge.
            bit_cnt <= nxt;
            sh      <= {sh[FRAME_LEN-3:0], 1'b1};
            mdio_o  <= sh[FRAME_LEN-2];
            mdio_oe <= wr || (nxt < 6'(BIT_TA));
          end
        end
      end
    end
  end

endmodule

// File: rtl/rgmii_link_ctrl.sv
// MDIO link controller: periodic PHY status poll, poll/host arbiter
// and the published speed/link/duplex status.
module rgmii_link_ctrl
  import mdio_pkg::*;
#(
  parameter logic [4:0] PHY_ADDR      = 5'd0,
  parameter int         MDC_DIV       = 20,
  parameter int         POLL_INTERVAL = 1000000,
  parameter logic [4:0] POLL_REG      = 5'h11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [4:0]  req_reg,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        mdc,
  input  logic        mdio_i,
  output logic        mdio_o,
  output logic        mdio_oe,
  output logic [1:0]  speed,
  output logic        link_up,
  output logic        duplex,
  output logic        status_valid,
  output logic        link_change
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FRAME = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam int TW = $clog2(POLL_INTERVAL);
  localparam logic [TW-1:0] T_LAST = TW'(POLL_INTERVAL - 1);

  logic [1:0]    state;
  logic [TW-1:0] timer;
  logic          poll_pending;
  logic          last_host;
  logic          owner_poll;
  logic          grant_poll;
  logic          start;
  logic          poll_end;
  logic          m_done;
  logic [15:0]   m_rdata;
  logic          new_link;
  mdio_req_t     mreq;

  assign grant_poll = (state == IDLE) && poll_pending &&
                      (!req_valid || last_host);
  assign req_ready  = !rst && (state == IDLE) && !grant_poll;
  assign start      = grant_poll || (req_valid && req_ready);
  assign poll_end   = (state == FRAME) && m_done && owner_poll;
  assign new_link   = m_rdata[STS_LINK];

  always_comb begin
    mreq = '{write: req_write, regad: req_reg, wdata: req_wdata};
    if (grant_poll)
      mreq = '{write: 1'b0, regad: POLL_REG, wdata: 16'h0};
  end

  mdio_master #(
    .PHY_ADDR (PHY_ADDR),
    .MDC_DIV  (MDC_DIV)
  ) u_master (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .req     (mreq),
    .mdio_i  (mdio_i),
    .mdc     (mdc),
    .mdio_o  (mdio_o),
    .mdio_oe (mdio_oe),
    .done    (m_done),
    .rdata   (m_rdata)
  );

  // Timer parks at its last value until the pending poll completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer        <= '0;
      poll_pending <= 1'b0;
    end else if (poll_end) begin
      timer        <= '0;
      poll_pending <= 1'b0;
    end else if (!poll_pending) begin
      if (timer == T_LAST)
        poll_pending <= 1'b1;
      else
        timer <= timer + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      last_host    <= 1'b0;
      owner_poll   <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= '0;
      speed        <= SPD_1000M;
      link_up      <= 1'b0;
      duplex       <= 1'b1;
      status_valid <= 1'b0;
      link_change  <= 1'b0;
    end else begin
      rsp_valid   <= 1'b0;
      link_change <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state      <= FRAME;
            owner_poll <= grant_poll;
            last_host  <= !grant_poll;
          end
        end
        FRAME: begin
          if (m_done) begin
            state <= DONE;
            if (owner_poll) begin
              link_change  <= new_link ^ link_up;
              link_up      <= new_link;
              duplex       <= m_rdata[STS_DUPLEX];
              status_valid <= 1'b1;
              if (new_link && spd_ok(m_rdata[STS_SPD +: 2]))
                speed <= m_rdata[STS_SPD +: 2];
            end else begin
              rsp_valid <= 1'b1;
              rsp_rdata <= m_rdata;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rgmii_link_ctrl.sv
// Randomized bench for rgmii_link_ctrl with a frame-level PHY model
// and a status model built from the PHY register contents.
module tb_rgmii_link_ctrl;

  localparam int MDC_DIV = 2;
  localparam int PI      = 200;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [4:0]  req_reg = '0;
  logic [15:0] req_wdata = '0;
  logic        mdio_i = 1'b1;
  logic        req_ready, rsp_valid, mdc, mdio_o, mdio_oe;
  logic [15:0] rsp_rdata;
  logic [1:0]  speed;
  logic        link_up, duplex, status_valid, link_change;

  always #5 clk = ~clk;

  rgmii_link_ctrl #(
    .PHY_ADDR      (5'd0),
    .MDC_DIV       (MDC_DIV),
    .POLL_INTERVAL (PI),
    .POLL_REG      (5'h11)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_reg      (req_reg),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .mdc          (mdc),
    .mdio_i       (mdio_i),
    .mdio_o       (mdio_o),
    .mdio_oe      (mdio_oe),
    .speed        (speed),
    .link_up      (link_up),
    .duplex       (duplex),
    .status_valid (status_valid),
    .link_change  (link_change)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [15:0] phy_regs [32];
  logic [63:0] cap_o, cap_oe, host_o, host_oe;
  logic [15:0] rd_data;
  int          idx = 0;
  bit          reading = 0;
  bit          host_busy = 0;
  bit          flog [$];
  int          poll_cnt = 0;
  int          lc_cnt = 0;
  int          rsp_cnt = 0;

  logic        m_link = 1'b0;
  logic        m_dup = 1'b1;
  logic [1:0]  m_speed = 2'b10;
  logic        m_valid = 1'b0;
  int          m_lc = 0;

  task automatic frame_end();
    logic [4:0]  ra;
    logic [15:0] d;
    ra = cap_o[22:18];
    if (cap_o[29:28] == 2'b01) phy_regs[ra] = cap_o[15:0];
    if (host_busy) begin
      flog.push_back(1'b1);
      host_o  = cap_o;
      host_oe = cap_oe;
    end else begin
      flog.push_back(1'b0);
      poll_cnt++;
      d = rd_data;
      if (d[10] != m_link) m_lc++;
      m_link = d[10];
      m_dup  = d[13];
      if (d[10] && d[15:14] != 2'b11) m_speed = d[15:14];
      m_valid = 1'b1;
    end
  endtask

  always @(posedge mdio_oe) begin
    idx = 0;
    reading = 0;
    mdio_i = 1'b1;
    cap_o = '0;
    cap_oe = '0;
  end

  always @(posedge mdc) begin
    cap_o  = {cap_o[62:0], mdio_o};
    cap_oe = {cap_oe[62:0], mdio_oe};
    idx++;
    if (idx == 46 && cap_o[11:10] == 2'b10) begin
      reading = 1;
      rd_data = phy_regs[cap_o[4:0]];
    end
    if (idx == 64) frame_end();
  end

  always @(negedge mdc)
    if (reading && idx >= 48 && idx < 64) mdio_i = rd_data[63-idx];

  always @(posedge clk) begin
    if (link_change) lc_cnt++;
    if (rsp_valid) rsp_cnt++;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(output bit ok);
    ok = 0;
    for (int i = 0; i < 2000; i++) begin
      if (req_ready) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic do_req(input logic w, input logic [4:0] r,
                        input logic [15:0] d);
    logic [15:0] exp_rd;
    logic [63:0] ef, em;
    int          n;
    bit          ok;
    exp_rd = w ? 16'h0 : phy_regs[r];
    @(negedge clk);
    req_valid = 1'b1;
    req_write = w;
    req_reg   = r;
    req_wdata = d;
    wait_ready(ok);
    if (!ok) begin
      req_valid = 1'b0;
      chk("hs_timeout", 64'(ok), 64'(1));
      return;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_write = 1'($urandom);
    req_reg   = 5'($urandom);
    req_wdata = 16'($urandom);
    host_busy = 1;
    n = 0;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk);
      #1;
      n++;
      if (rsp_valid) break;
    end
    chk("latency", 64'(n), 64'(128 * MDC_DIV + 1));
    chk("rdata", 64'(rsp_rdata), 64'(exp_rd));
    host_busy = 0;
    ef = {32'hFFFF_FFFF, 2'b01, (w ? 2'b01 : 2'b10), 5'd0, r,
          2'b10, (w ? d : 16'h0)};
    em = w ? '1 : {{46{1'b1}}, 18'b0};
    chk("oe_map", host_oe, em);
    chk("frame", host_o & em, ef & em);
  endtask

  task automatic chk_status();
    chk("link_up", 64'(link_up), 64'(m_link));
    chk("speed", 64'(speed), 64'(m_speed));
    chk("duplex", 64'(duplex), 64'(m_dup));
    chk("status_valid", 64'(status_valid), 64'(m_valid));
    chk("link_change_cnt", 64'(lc_cnt), 64'(m_lc));
  endtask

  task automatic wait_poll();
    int p;
    p = poll_cnt;
    for (int i = 0; i < 3000; i++) begin
      if (poll_cnt > p) break;
      @(posedge clk);
    end
    if (poll_cnt == p) chk("poll_timeout", 64'(poll_cnt), 64'(p + 1));
    cyc(6);
  endtask

  initial begin
    int s, np, r0;
    bit ok;
    logic w;
    logic [4:0] r;

    for (int i = 0; i < 32; i++) phy_regs[i] = 16'($urandom);
    phy_regs[17] = 16'h6400;
    phy_regs[2]  = 16'h001C;

    #1 rst = 1'b1;
    cyc(3);
    chk("rst_mdc", 64'(mdc), 64'(0));
    chk("rst_mdio_o", 64'(mdio_o), 64'(1));
    chk("rst_mdio_oe", 64'(mdio_oe), 64'(0));
    chk("rst_req_ready", 64'(req_ready), 64'(0));
    chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rst_rsp_rdata", 64'(rsp_rdata), 64'(0));
    chk("rst_link_change", 64'(link_change), 64'(0));
    chk_status();
    @(negedge clk) rst = 1'b0;

    wait_poll();
    chk_status();
    chk("first_speed", 64'(speed), 64'(2'b01));
    chk("first_lc", 64'(lc_cnt), 64'(1));

    do_req(1'b0, 5'h02, 16'h0);
    do_req(1'b1, 5'h00, 16'h1140);

    s = flog.size();
    repeat (6) do_req(1'b0, 5'($urandom), 16'h0);
    np = 0;
    for (int i = s; i < flog.size(); i++) if (!flog[i]) np++;
    for (int i = s + 1; i < flog.size(); i++)
      if (flog[i]) chk("alternate", 64'(flog[i-1]), 64'(0));
    chk("poll_not_starved", 64'(np >= 5), 64'(1));

    phy_regs[17] = 16'h8000;
    wait_poll();
    wait_poll();
    chk_status();
    chk("down_speed_hold", 64'(speed), 64'(2'b01));

    phy_regs[17] = 16'hE400;
    wait_poll();
    wait_poll();
    chk_status();
    chk("rsvd_speed_hold", 64'(speed), 64'(2'b01));

    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_reg   = 5'h02;
    wait_ready(ok);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    host_busy = 1;
    for (int i = 0; i < 1000; i++) begin
      if (idx >= 40) break;
      @(posedge clk);
    end
    r0 = rsp_cnt;
    rst = 1'b1;
    host_busy = 0;
    m_link = 1'b0;
    m_dup = 1'b1;
    m_speed = 2'b10;
    m_valid = 1'b0;
    #1;
    chk("abort_mdc", 64'(mdc), 64'(0));
    chk("abort_oe", 64'(mdio_oe), 64'(0));
    cyc(3);
    @(negedge clk) rst = 1'b0;
    cyc(100);
    chk_status();
    cyc(200);
    chk("abort_no_rsp", 64'(rsp_cnt), 64'(r0));
    do_req(1'b0, 5'h02, 16'h0);

    repeat (12) begin
      w = 1'($urandom_range(0, 1));
      r = 5'($urandom_range(0, 31));
      do_req(w, r, 16'($urandom));
      if ($urandom_range(0, 2) == 0) begin
        phy_regs[17] = 16'($urandom);
        wait_poll();
        wait_poll();
        chk_status();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
